uart_rx_fifo_param: RTL

Parametrised successor to the fixed 8N1 receive path of the PicoBlaze UART peripheral. It deserialises asynchronous serial input at 16x oversampling, with runtime-selectable parity and stop bits. Each received word is stored in a depth-parametrised first-word-fall-through FIFO together with per-word parity, framing and break status. Sticky overrun reporting is provided. It sits between the baud generator (en_16_x_baud) and the register block (buffer_read, data_out, status).

---
 rtl/uart_rx_fifo_param.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo_param.sv
// uart_rx_fifo_param: 16x oversampled UART receiver with runtime parity/stop options feeding a status-tagged FWFT FIFO
module uart_rx_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  serial_in,
  input  logic                  en_16_x_baud,
  input  logic [1:0]            parity_mode,
  input  logic                  two_stop,
  input  logic                  buffer_reset,
  input  logic                  buffer_read,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  break_det,
  output logic                  buffer_data_present,
  output logic                  buffer_half_full,
  output logic                  buffer_full,
  output logic [CNT_WIDTH-1:0]  fill_level,
  output logic                  overrun
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int W  = DATA_WIDTH + 3;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;
  state_t state, state_nx;
  logic s1, s2, rx;
  logic [3:0] cnt, cnt_nx, bit_cnt, bit_nx;
  logic [DATA_WIDTH-1:0] sh, sh_nx;
  logic [1:0] pm, pm_nx;
  logic ts, ts_nx, pe, pe_nx, fe, fe_nx, pz, pz_nx, brk, brk_nx;
  logic push, brk_now, fe_now;
  logic [W-1:0] push_word, head;
  logic [W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CNT_WIDTH-1:0] count;
  logic empty, full, do_rd, do_wr;
  assign rx = s2;
  // two-flop synchroniser for the asynchronous line, idling high
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= serial_in;
      s2 <= s1;
    end
  // receive state register; buffer_reset abandons any frame in progress
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      sh <= '0;
      pm <= '0;
      ts <= 1'b0;
      pe <= 1'b0;
      fe <= 1'b0;
      pz <= 1'b1;
      brk <= 1'b0;
    end else if (buffer_reset) begin
      state <= IDLE;
      cnt <= '0;
      bit_cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      bit_cnt <= bit_nx;
      sh <= sh_nx;
      pm <= pm_nx;
      ts <= ts_nx;
      pe <= pe_nx;
      fe <= fe_nx;
      pz <= pz_nx;
      brk <= brk_nx;
    end
  // stop-bit status as it stands on the final stop sample, used for the pushed entry
  always_comb begin
    brk_now = (state == STOP1) ? (sh == '0) && pz && !rx : brk;
    fe_now  = (state == STOP1) ? !rx : fe | !rx;
  end
  // next-state logic: everything advances only on a baud tick; samples fall at bit centres
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    bit_nx = bit_cnt;
    sh_nx = sh;
    pm_nx = pm;
    ts_nx = ts;
    pe_nx = pe;
    fe_nx = fe;
    pz_nx = pz;
    brk_nx = brk;
    push = 1'b0;
    if (en_16_x_baud) begin
      cnt_nx = cnt + 4'd1;
      case (state)
        IDLE: begin
          cnt_nx = '0;
          if (!rx) begin
            state_nx = START;
            pm_nx = parity_mode;
            ts_nx = two_stop;
          end
        end
        START: if (cnt == 4'd7) begin
          cnt_nx = '0;
          bit_nx = '0;
          pe_nx = 1'b0;
          fe_nx = 1'b0;
          pz_nx = 1'b1;
          brk_nx = 1'b0;
          state_nx = rx ? IDLE : DATA;
        end
        DATA: if (cnt == 4'd15) begin
          sh_nx = {rx, sh[DATA_WIDTH-1:1]};
          bit_nx = bit_cnt + 4'd1;
          if (bit_cnt == 4'(DATA_WIDTH - 1)) state_nx = (pm[0] ^ pm[1]) ? PARITY : STOP1;
        end
        PARITY: if (cnt == 4'd15) begin
          pe_nx = ((^sh) ^ rx) != (pm == 2'b01);
          pz_nx = !rx;
          state_nx = STOP1;
        end
        STOP1: if (cnt == 4'd15) begin
          fe_nx = fe_now;
          brk_nx = brk_now;
          push = !ts;
          state_nx = ts ? STOP2 : IDLE;
        end
        STOP2: if (cnt == 4'd15) begin
          fe_nx = fe_now;
          push = 1'b1;
          state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end
  assign push_word = {brk_now, fe_now, pe, sh_nx};
  assign empty = count == '0;
  assign full = count == CNT_WIDTH'(FIFO_DEPTH);
  assign do_rd = buffer_read && !empty && !buffer_reset;
  assign do_wr = push && (!full || do_rd) && !buffer_reset;
  // FIFO storage; the head is qualified by occupancy so unused entries need no reset
  always_ff @(posedge clk)
    if (do_wr) mem[wr_ptr] <= push_word;
  // FIFO pointers, occupancy and sticky overrun
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overrun <= 1'b0;
    end else if (buffer_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overrun <= 1'b0;
    end else begin
      wr_ptr <= do_wr ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_rd ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + CNT_WIDTH'(do_wr) - CNT_WIDTH'(do_rd);
      overrun <= overrun | (push && !do_wr);
    end
  assign head = empty ? '0 : mem[rd_ptr];
  assign {break_det, frame_err, parity_err, data_out} = head;
  assign buffer_data_present = !empty;
  assign buffer_half_full = count >= CNT_WIDTH'(FIFO_DEPTH / 2);
  assign buffer_full = full;
  assign fill_level = count;
endmodule
